// File: rtl/fetch_sequencer_pkg.sv
// Shared A09 control definitions: state codes, opcodes and datapath mux
// select codes. The datapath and its benches reuse these constants.
package fetch_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int STATE_W  = 4;

  // Sequencer state codes; also reported on the debug state output.
  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 4'd0,
    S_VECTOR    = 4'd1,
    S_FETCH     = 4'd2,
    S_READ      = 4'd3,
    S_DECODE    = 4'd4,
    S_OPND_ADDR = 4'd5,
    S_OPND_READ = 4'd6,
    S_HALT      = 4'd7,
    S_FAULT     = 4'd8
  } state_e;

  // Opcodes decoded from IR[3:0].
  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_BRZ  = 4'd3;

  // PC mux select codes.
  localparam int PC_SRC_PC     = 0;
  localparam int PC_SRC_MEM    = 1;
  localparam int PC_SRC_VECTOR = 2;

  // Address mux select codes.
  localparam int ADDR_SRC_PC = 0;

  // True for the two states that hold a memory read request open.
  function automatic logic is_read_state(input state_e s);
    return (s == S_READ) || (s == S_OPND_READ);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port between the fetch sequencer and the memory.
//
// Handshake: mem_rd_o is a request held high for as long as the sequencer
// waits for data. mem_ack_i is high for the single cycle in which read data
// is valid; the sequencer consumes the data in that same cycle and drops
// the request on the next one. An ack with no request pending is ignored.
interface fetch_sequencer_if;
  logic mem_rd_o;
  logic mem_ack_i;

  modport master (output mem_rd_o, input mem_ack_i);
  modport slave  (input mem_rd_o, output mem_ack_i);
endinterface

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// Read wait watchdog: counts cycles a read has waited for its ack and
// flags the last permitted cycle. The count saturates instead of wrapping.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise step while waiting and below LAST.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// A09 fetch/sequence controller: reset-vector load, instruction fetch,
// decode of NOP/HALT/JMP/BRZ and operand fetch for taken jumps. Drives the
// active-low datapath register controls and mux selects (Mealy outputs).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter int MEM_TIMEOUT      = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  fetch_sequencer_if.master           mem,
  input  logic [OPCODE_W-1:0]         opcode_i,
  input  logic                        zero_i,
  output logic                        pc_rst_no,
  output logic                        pc_ld_no,
  output logic                        pc_inc_no,
  output logic                        mar_rst_no,
  output logic                        mar_ld_no,
  output logic                        ir_ld_no,
  output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
  output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
  output logic                        halt_o,
  output logic                        fault_o,
  output logic [STATE_W-1:0]          state_o
);

  // An IR narrower than the opcode field can never hold a valid opcode.
  localparam bit IR_HOLDS_OPCODE = (DATA_WIDTH >= OPCODE_W);

  state_e state_q;
  state_e state_d;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Mealy outputs; reset_i overrides the current state so a
  // pending read request drops in the very cycle reset is raised.
  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    pc_rst_no   = 1'b1;
    pc_ld_no    = 1'b1;
    pc_inc_no   = 1'b1;
    mar_rst_no  = 1'b1;
    mar_ld_no   = 1'b1;
    ir_ld_no    = 1'b1;
    mem.mem_rd_o = 1'b0;
    pc_src_o    = PC_SELECT_SIZE'(PC_SRC_PC);
    addr_src_o  = ADDR_SELECT_SIZE'(ADDR_SRC_PC);
    halt_o      = 1'b0;
    fault_o     = 1'b0;

    if (reset_i) begin
      pc_rst_no  = 1'b0;
      mar_rst_no = 1'b0;
      state_d    = S_RESET;
    end else begin
      case (state_q)
        S_RESET: begin
          pc_rst_no  = 1'b0;
          mar_rst_no = 1'b0;
          state_d    = S_VECTOR;
        end
        S_VECTOR: begin
          pc_src_o = PC_SELECT_SIZE'(PC_SRC_VECTOR);
          pc_ld_no = 1'b0;
          state_d  = S_FETCH;
        end
        S_FETCH, S_OPND_ADDR: begin
          addr_src_o  = ADDR_SELECT_SIZE'(ADDR_SRC_PC);
          mar_ld_no   = 1'b0;
          timer_clear = 1'b1;
          state_d     = (state_q == S_FETCH) ? S_READ : S_OPND_READ;
        end
        S_READ, S_OPND_READ: begin
          mem.mem_rd_o = is_read_state(state_q);
          if (mem.mem_ack_i) begin
            if (state_q == S_READ) begin
              ir_ld_no  = 1'b0;
              pc_inc_no = 1'b0;
              state_d   = S_DECODE;
            end else begin
              pc_src_o = PC_SELECT_SIZE'(PC_SRC_MEM);
              pc_ld_no = 1'b0;
              state_d  = S_FETCH;
            end
          end else begin
            // An ack on the last permitted cycle is taken above.
            timer_en = 1'b1;
            if (timer_expired) begin
              state_d = S_FAULT;
            end
          end
        end
        S_DECODE: begin
          if (!IR_HOLDS_OPCODE) begin
            state_d = S_FAULT;
          end else begin
            case (opcode_i)
              OP_NOP:  state_d = S_FETCH;
              OP_HALT: state_d = S_HALT;
              OP_JMP:  state_d = S_OPND_ADDR;
              OP_BRZ: begin
                if (zero_i) begin
                  state_d = S_OPND_ADDR;
                end else begin
                  // Untaken: step the PC over the operand word.
                  pc_inc_no = 1'b0;
                  state_d   = S_FETCH;
                end
              end
              default: state_d = S_FAULT;
            endcase
          end
        end
        S_HALT: begin
          halt_o = 1'b1;
        end
        S_FAULT: begin
          fault_o = 1'b1;
        end
        default: begin
          state_d = S_FAULT;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a small A09 datapath (PC, MAR, IR, memory)
// driven by the DUT's controls, a per-cycle expected-output queue built
// from the instruction-level timing rules, and a tracked program counter.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] opcode;
  logic       zero = 1'b0;
  logic       pc_rst_no, pc_ld_no, pc_inc_no, mar_rst_no, mar_ld_no, ir_ld_no;
  logic [2:0] pc_src;
  logic [1:0] addr_src;
  logic       halt, fault;
  logic [3:0] dbg_state;

  fetch_sequencer_if mif ();

  fetch_sequencer #(
    .DATA_WIDTH(8), .PC_SELECT_SIZE(3), .ADDR_SELECT_SIZE(2), .MEM_TIMEOUT(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .mem(mif), .opcode_i(opcode), .zero_i(zero),
    .pc_rst_no(pc_rst_no), .pc_ld_no(pc_ld_no), .pc_inc_no(pc_inc_no),
    .mar_rst_no(mar_rst_no), .mar_ld_no(mar_ld_no), .ir_ld_no(ir_ld_no),
    .pc_src_o(pc_src), .addr_src_o(addr_src), .halt_o(halt), .fault_o(fault),
    .state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench datapath ----------------
  logic [7:0] mem [256];
  logic [7:0] pc_r  = 8'h00;
  logic [7:0] mar_r = 8'h00;
  logic [7:0] ir_r  = 8'h00;

  always @(posedge clk) begin
    if (!pc_rst_no) pc_r <= 8'h00;
    else if (!pc_ld_no) pc_r <= (pc_src == 3'd2) ? 8'hFF : mem[mar_r];
    else if (!pc_inc_no) pc_r <= pc_r + 8'h01;
    if (!mar_rst_no) mar_r <= 8'h00;
    else if (!mar_ld_no) mar_r <= pc_r;
    if (!ir_ld_no && mif.mem_ack_i) ir_r <= mem[mar_r];
  end
  assign opcode = ir_r[3:0];

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp_q [$];
  logic [13:0] exp_v;
  logic [13:0] act;
  logic [7:0]  exp_pc;

  assign act = {pc_rst_no, pc_ld_no, pc_inc_no, mar_rst_no, mar_ld_no, ir_ld_no,
                mif.mem_rd_o, pc_src, addr_src, halt, fault};

  function automatic logic [13:0] mk(input logic prst, pld, pinc, mrst, mld, irld, rd,
                                     input logic [2:0] psrc, input logic [1:0] asrc,
                                     input logic h, f);
    return {prst, pld, pinc, mrst, mld, irld, rd, psrc, asrc, h, f};
  endfunction

  logic [13:0] E_IDLE, E_RESET, E_VECTOR, E_FETCH, E_WAIT, E_ACK, E_SKIP, E_OPND;
  logic [13:0] E_HALT, E_FAULT;

  // Compare every cycle that has an expectation queued.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b want=%b (prst pld pinc mrst mld irld rd psrc asrc h f)",
                 $time, act, exp_v);
      end
      checks++;
      if (!pc_ld_no && !pc_inc_no) begin
        errors++;
        $display("FAIL ld_inc_overlap t=%0t pc_ld_no=%b pc_inc_no=%b want not both 0",
                 $time, pc_ld_no, pc_inc_no);
      end
    end
  end

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rst, input logic ack, input logic z, input logic [13:0] e);
    @(posedge clk);
    #1;
    reset_i       = rst;
    mif.mem_ack_i = ack;
    zero          = z;
    exp_q.push_back(e);
  endtask

  // n cycles with reset high, then the RESET and VECTOR cycles.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, E_RESET);
    cyc(1'b0, 1'b0, 1'b0, E_RESET);
    cyc(1'b0, 1'b0, 1'b0, E_VECTOR);
    exp_pc = 8'hFF;
  endtask

  // FETCH plus READ with w wait cycles before the ack; checks fetch address.
  task automatic fetch(input int w, input logic [7:0] lit);
    cyc(1'b0, 1'b0, 1'b0, E_FETCH);
    for (int i = 0; i <= w; i++) begin
      cyc(1'b0, (i == w), 1'b0, (i == w) ? E_ACK : E_WAIT);
      if (i == 0) begin
        chk8("fetch_addr_model", mar_r, exp_pc);
        chk8("fetch_addr_lit", mar_r, lit);
      end
    end
    exp_pc = exp_pc + 8'h01;
  endtask

  task automatic do_nop(input int w, input logic [7:0] lit);
    fetch(w, lit);
    cyc(1'b0, 1'b0, 1'b0, E_IDLE);
  endtask

  // JMP or BRZ at lit; taken when JMP, or BRZ with z set.
  task automatic do_branch(input logic z, input logic [7:0] lit);
    logic taken;
    taken = (mem[lit][3:0] == 4'd2) || z;
    fetch(0, lit);
    if (!taken) begin
      cyc(1'b0, 1'b0, z, E_SKIP);
      exp_pc = exp_pc + 8'h01;
    end else begin
      cyc(1'b0, 1'b0, z, E_IDLE);
      cyc(1'b0, 1'b0, 1'b0, E_FETCH);
      cyc(1'b0, 1'b1, 1'b0, E_OPND);
      chk8("opnd_addr", mar_r, exp_pc);
      exp_pc = mem[exp_pc];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    E_IDLE   = mk(1, 1, 1, 1, 1, 1, 0, 3'd0, 2'd0, 0, 0);
    E_RESET  = mk(0, 1, 1, 0, 1, 1, 0, 3'd0, 2'd0, 0, 0);
    E_VECTOR = mk(1, 0, 1, 1, 1, 1, 0, 3'd2, 2'd0, 0, 0);
    E_FETCH  = mk(1, 1, 1, 1, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    E_WAIT   = mk(1, 1, 1, 1, 1, 1, 1, 3'd0, 2'd0, 0, 0);
    E_ACK    = mk(1, 1, 0, 1, 1, 0, 1, 3'd0, 2'd0, 0, 0);
    E_SKIP   = mk(1, 1, 0, 1, 1, 1, 0, 3'd0, 2'd0, 0, 0);
    E_OPND   = mk(1, 0, 1, 1, 1, 1, 1, 3'd1, 2'd0, 0, 0);
    E_HALT   = mk(1, 1, 1, 1, 1, 1, 0, 3'd0, 2'd0, 1, 0);
    E_FAULT  = mk(1, 1, 1, 1, 1, 1, 0, 3'd0, 2'd0, 0, 1);
    mif.mem_ack_i = 1'b0;
    exp_pc = 8'hFF;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h00;                     // NOP
    mem[8'h00] = 8'h00;                     // NOP
    mem[8'h01] = 8'h02; mem[8'h02] = 8'h40; // JMP 0x40
    mem[8'h40] = 8'h03; mem[8'h41] = 8'h50; // BRZ 0x50 (untaken)
    mem[8'h42] = 8'h03; mem[8'h43] = 8'h60; // BRZ 0x60 (taken)
    mem[8'h60] = 8'h00;                     // NOP, slow ack
    mem[8'h61] = 8'h00;                     // NOP, ack on last cycle
    mem[8'h62] = 8'h01;                     // HALT

    // Reset held 3 cycles; NOPs from the vector, then branches.
    do_reset(3);
    do_nop(0, 8'hFF);
    do_nop(0, 8'h00);
    do_branch(1'b0, 8'h01);
    do_branch(1'b0, 8'h40);
    do_branch(1'b1, 8'h42);
    do_nop(5, 8'h60);
    do_nop(15, 8'h61);
    fetch(0, 8'h62);
    cyc(1'b0, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, E_HALT);

    // Reset raised in the middle of a read.
    do_reset(2);
    do_nop(0, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, E_FETCH);
    cyc(1'b0, 1'b0, 1'b0, E_WAIT);
    cyc(1'b0, 1'b0, 1'b0, E_WAIT);
    do_reset(2);

    // No ack at all: 16 READ cycles, then FAULT sticks.
    do_nop(0, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, E_FETCH);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, E_WAIT);
      if (i == 0) chk8("timeout_addr", mar_r, 8'h00);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, E_FAULT);

    // Illegal opcode faults after DECODE.
    mem[8'hFF] = 8'h0F;
    do_reset(2);
    fetch(0, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, E_FAULT);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
